// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared types and constants for the byte-serial memory controller.
//   word_t      32-bit data word
//   state_t     controller FSM states
//   SIZE_*      d_size encodings (10 and 11 both mean word)
//   GNT_*       arbiter last-grant encodings
//   size_bytes  d_size -> number of bytes to transfer
package mem_ctrl_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic GNT_IC = 1'b0;
  localparam logic GNT_D  = 1'b1;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 3'd1;
      SIZE_HALF: return 3'd2;
      default:   return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_arb.sv
// mem_rr_arb: two-way round-robin arbiter between icache refill and data path.
// Grant is combinational; last_grant is registered and updated when the
// controller accepts a grant (take). On a tie the requester not granted last
// wins; reset leaves last_grant = data so the first tie goes to the icache.
//   clk, rst        clock, synchronous active-high reset
//   req_ic, req_d   requests (already qualified by the controller being idle)
//   take            controller accepted the current grant this cycle
//   gnt_ic, gnt_d   one-hot (or zero) grant
module mem_rr_arb
  import mem_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_ic,
  input  logic req_d,
  input  logic take,
  output logic gnt_ic,
  output logic gnt_d
);

  logic last_grant;

  assign gnt_ic = req_ic && (!req_d || last_grant == GNT_D);
  assign gnt_d  = req_d && (!req_ic || last_grant == GNT_IC);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= GNT_D;
    end else if (take) begin
      last_grant <= gnt_d ? GNT_D : GNT_IC;
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial main-memory controller shared by icache refill and
// load/store. Arbitrates (mem_rr_arb), then issues LINE_BYTES reads for a
// refill or 1/2/4 reads/writes for a data access. All outputs registered.
// Optional build macro: MEMCTL_IOSTALL_EN - stores to addresses with
// addr[17:16]==2'b11 hold off while io_buffer_full is high.
//   clk, rst              clock, synchronous active-high reset
//   ic_req/ic_addr        refill request and line address
//   ic_abort              cancel in-flight refill
//   ic_done/ic_line       refill done pulse and line data
//   d_req/d_wr/d_size     data request, store flag, size
//   d_addr/d_wdata        data address and store data
//   d_done/d_rdata        data done pulse and zero-extended load data
//   mem_din/mem_dout      RAM read/write byte
//   mem_a/mem_wr          RAM address and write strobe
//   io_buffer_full        IO sink back-pressure
//
// state   | meaning
// IDLE    | waiting for a request; grant edge also issues byte 0
// BUSY    | issuing bytes (cnt = next byte) and capturing read data
// DONE    | done pulse for one cycle, requests ignored
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int LINE_BYTES = 16,
  parameter int ADDR_W     = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ic_req,
  input  logic [ADDR_W-1:0]       ic_addr,
  input  logic                    ic_abort,
  output logic                    ic_done,
  output logic [8*LINE_BYTES-1:0] ic_line,
  input  logic                    d_req,
  input  logic                    d_wr,
  input  logic [1:0]              d_size,
  input  logic [ADDR_W-1:0]       d_addr,
  input  word_t                   d_wdata,
  output logic                    d_done,
  output word_t                   d_rdata,
  input  logic [7:0]              mem_din,
  output logic [7:0]              mem_dout,
  output logic [ADDR_W-1:0]       mem_a,
  output logic                    mem_wr,
  input  logic                    io_buffer_full
);

  localparam int OFF_W = $clog2(LINE_BYTES);
  // cnt runs up to LINE_BYTES+1 (last read capture edge)
  localparam int CNT_W = OFF_W + 1;

  state_t                  state, state_n;
  logic                    op_ic, op_ic_n, op_wr, op_wr_n;
  logic [ADDR_W-1:0]       base, base_n, mem_a_n;
  logic [CNT_W-1:0]        len, len_n, cnt, cnt_n, cap_idx;
  word_t                   wdata, wdata_n, d_rdata_n;
  logic [8*LINE_BYTES-1:0] ic_line_n;
  logic [7:0]              mem_dout_n;
  logic                    mem_wr_n, ic_done_n, d_done_n;
  logic                    gnt_ic, gnt_d, take;
  logic [ADDR_W-1:0]       grant_a, issue_a;
  logic                    grant_wr, stall_grant, stall_busy;
  logic                    unused_ok;

  mem_rr_arb u_arb (
    .clk    (clk),
    .rst    (rst),
    .req_ic (ic_req && state == ST_IDLE),
    .req_d  (d_req && state == ST_IDLE),
    .take   (take),
    .gnt_ic (gnt_ic),
    .gnt_d  (gnt_d)
  );

  assign grant_a  = gnt_ic ? {ic_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : d_addr;
  assign grant_wr = gnt_d && d_wr;
  assign issue_a  = base + ADDR_W'(cnt);
  // read byte k is captured two edges after its issue edge, i.e. at cnt = k+2
  assign cap_idx  = cnt - CNT_W'(2);

`ifdef MEMCTL_IOSTALL_EN
  assign stall_grant = grant_wr && grant_a[17:16] == 2'b11 && io_buffer_full;
  assign stall_busy  = op_wr && issue_a[17:16] == 2'b11 && io_buffer_full;
`else
  assign stall_grant = FALSE;
  assign stall_busy  = FALSE;
`endif

  assign unused_ok = ^{ic_addr[OFF_W-1:0], io_buffer_full};

  always_comb begin
    state_n    = state;
    op_ic_n    = op_ic;
    op_wr_n    = op_wr;
    base_n     = base;
    len_n      = len;
    cnt_n      = cnt;
    wdata_n    = wdata;
    ic_line_n  = ic_line;
    d_rdata_n  = d_rdata;
    mem_a_n    = mem_a;
    mem_dout_n = mem_dout;
    mem_wr_n   = FALSE;
    ic_done_n  = FALSE;
    d_done_n   = FALSE;
    take       = FALSE;
    case (state)
      ST_IDLE: begin
        if (gnt_ic || gnt_d) begin
          take    = TRUE;
          state_n = ST_BUSY;
          op_ic_n = gnt_ic;
          op_wr_n = grant_wr;
          base_n  = grant_a;
          len_n   = gnt_ic ? CNT_W'(LINE_BYTES) : CNT_W'(size_bytes(d_size));
          wdata_n = d_wdata;
          if (gnt_d && !d_wr) d_rdata_n = '0;
          if (stall_grant) begin
            cnt_n = '0;
          end else begin
            mem_a_n  = grant_a;
            mem_wr_n = grant_wr;
            if (grant_wr) mem_dout_n = d_wdata[7:0];
            cnt_n    = CNT_W'(1);
          end
        end
      end
      ST_BUSY: begin
        if (op_ic && ic_abort) begin
          state_n = ST_IDLE;
        end else begin
          if (cnt < len) begin
            if (!stall_busy) begin
              mem_a_n  = issue_a;
              mem_wr_n = op_wr;
              if (op_wr) mem_dout_n = wdata[8*cnt[1:0] +: 8];
              cnt_n    = cnt + CNT_W'(1);
            end
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
          if (!op_wr && cnt >= CNT_W'(2)) begin
            if (op_ic) ic_line_n[8*cap_idx[OFF_W-1:0] +: 8] = mem_din;
            else       d_rdata_n[8*cap_idx[1:0] +: 8]       = mem_din;
          end
          if (cnt == len + CNT_W'(1)) begin
            state_n   = ST_DONE;
            ic_done_n = op_ic;
            d_done_n  = !op_ic;
          end
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      op_ic    <= FALSE;
      op_wr    <= FALSE;
      base     <= '0;
      len      <= '0;
      cnt      <= '0;
      wdata    <= '0;
      ic_line  <= '0;
      d_rdata  <= '0;
      mem_a    <= '0;
      mem_dout <= '0;
      mem_wr   <= FALSE;
      ic_done  <= FALSE;
      d_done   <= FALSE;
    end else begin
      state    <= state_n;
      op_ic    <= op_ic_n;
      op_wr    <= op_wr_n;
      base     <= base_n;
      len      <= len_n;
      cnt      <= cnt_n;
      wdata    <= wdata_n;
      ic_line  <= ic_line_n;
      d_rdata  <= d_rdata_n;
      mem_a    <= mem_a_n;
      mem_dout <= mem_dout_n;
      mem_wr   <= mem_wr_n;
      ic_done  <= ic_done_n;
      d_done   <= d_done_n;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed scoreboard bench for mem_ctrl. Expected done responses
// and RAM writes are queued by the stimulus; a negedge monitor pops and
// compares whenever the DUT pulses a done or strobes mem_wr.
module tb_mem_ctrl;

  localparam int LB = 16;
  localparam int AW = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ic_req = 1'b0, ic_abort = 1'b0, d_req = 1'b0, d_wr = 1'b0;
  logic [AW-1:0]     ic_addr = '0, d_addr = '0;
  logic [1:0]        d_size = '0;
  logic [31:0]       d_wdata = '0;
  logic              io_buffer_full = 1'b0;
  logic [7:0]        mem_din = '0;
  logic              ic_done, d_done, mem_wr;
  logic [8*LB-1:0]   ic_line;
  logic [31:0]       d_rdata;
  logic [7:0]        mem_dout;
  logic [AW-1:0]     mem_a;

  typedef struct {
    logic         is_ic;
    logic         chk;
    logic [127:0] data;
  } resp_t;
  typedef struct {
    logic [31:0] a;
    logic [7:0]  d;
  } wr_t;

  resp_t sb[$];
  wr_t   wq[$];
  resp_t mon_r;
  wr_t   mon_w;
  int    total = 0;
  int    bad = 0;
  int    wr_cnt = 0;
  int    wr_base;

  always #5 clk = ~clk;

  mem_ctrl #(.LINE_BYTES(LB), .ADDR_W(AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .ic_req         (ic_req),
    .ic_addr        (ic_addr),
    .ic_abort       (ic_abort),
    .ic_done        (ic_done),
    .ic_line        (ic_line),
    .d_req          (d_req),
    .d_wr           (d_wr),
    .d_size         (d_size),
    .d_addr         (d_addr),
    .d_wdata        (d_wdata),
    .d_done         (d_done),
    .d_rdata        (d_rdata),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .io_buffer_full (io_buffer_full)
  );

  // RAM model: one-cycle registered read, byte value = low address byte
  always @(posedge clk) mem_din <= mem_a[7:0];

  always @(negedge clk) begin
    if (!rst && (ic_done || d_done)) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL done_unexpected actual ic_done=%0b d_done=%0b required no done", ic_done, d_done);
      end else begin
        mon_r = sb.pop_front();
        if ({ic_done, d_done} != {mon_r.is_ic, !mon_r.is_ic}) begin
          bad++;
          $display("FAIL done_kind actual ic_done=%0b d_done=%0b required ic=%0b", ic_done, d_done, mon_r.is_ic);
        end else if (mon_r.chk && mon_r.is_ic && ic_line !== mon_r.data) begin
          bad++;
          $display("FAIL ic_line actual=%h required=%h", ic_line, mon_r.data);
        end else if (mon_r.chk && !mon_r.is_ic && d_rdata !== mon_r.data[31:0]) begin
          bad++;
          $display("FAIL d_rdata actual=%h required=%h", d_rdata, mon_r.data[31:0]);
        end
      end
    end
    if (!rst && mem_wr) begin
      wr_cnt++;
      total++;
      if (wq.size() == 0) begin
        bad++;
        $display("FAIL write_unexpected actual a=%h d=%h required no write", mem_a, mem_dout);
      end else begin
        mon_w = wq.pop_front();
        if (mem_a !== mon_w.a || mem_dout !== mon_w.d) begin
          bad++;
          $display("FAIL write actual a=%h d=%h required a=%h d=%h", mem_a, mem_dout, mon_w.a, mon_w.d);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] exp_line(input logic [31:0] base);
    logic [127:0] l;
    logic [31:0]  a;
    l = '0;
    for (int i = 0; i < LB; i++) begin
      a = base + i;
      l[8*i +: 8] = a[7:0];
    end
    return l;
  endfunction

  function automatic logic [127:0] exp_load(input logic [31:0] addr, input int n);
    logic [127:0] l;
    logic [31:0]  a;
    l = '0;
    for (int i = 0; i < n; i++) begin
      a = addr + i;
      l[8*i +: 8] = a[7:0];
    end
    return l;
  endfunction

  task automatic push_resp(input logic is_ic, input logic chk, input logic [127:0] data);
    resp_t r;
    r.is_ic = is_ic;
    r.chk   = chk;
    r.data  = data;
    sb.push_back(r);
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [7:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    wq.push_back(w);
  endtask

  // Ticks until a done pulse (bounded); checks the cycle count when exp_cyc > 0
  // and drops the finished requester's req in the done cycle.
  task automatic wait_done(input string name, input int exp_cyc);
    int  cyc;
    bit  seen;
    cyc  = 0;
    seen = 0;
    while (!seen && cyc < 60) begin
      tick();
      cyc++;
      if (ic_done || d_done) seen = 1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s_timeout actual no done after %0d cycles required done", name, cyc);
    end else if (exp_cyc > 0 && cyc != exp_cyc) begin
      bad++;
      $display("FAIL %s_latency actual=%0d required=%0d", name, cyc, exp_cyc);
    end
    if (ic_done) ic_req = 1'b0;
    if (d_done)  d_req  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset values
    repeat (3) tick();
    check("rst_ic_done", ic_done, 0);
    check("rst_d_done", d_done, 0);
    check("rst_mem_wr", mem_wr, 0);
    check("rst_mem_a", mem_a, 0);
    check("rst_mem_dout", mem_dout, 0);
    check("rst_ic_line", ic_line, 0);
    check("rst_d_rdata", d_rdata, 0);
    rst = 1'b0;
    tick();

    // refill 0x1004 -> line at 0x1000
    push_resp(1, 1, 128'h0F0E0D0C0B0A09080706050403020100);
    ic_addr = 32'h1004;
    ic_req  = 1'b1;
    for (int i = 0; i < LB; i++) begin
      tick();
      check("refill_addr", mem_a, 32'h1000 + i);
    end
    tick();
    check("refill_done_early", ic_done, 0);
    tick();
    check("refill_done_time", ic_done, 1);
    ic_req = 1'b0;
    tick();
    check("refill_done_pulse", ic_done, 0);

    // word load at unaligned 0x2002
    push_resp(0, 1, 128'h05040302);
    d_addr = 32'h2002;
    d_size = 2'b10;
    d_wr   = 1'b0;
    d_req  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("load_addr", mem_a, 32'h2002 + i);
    end
    tick();
    check("load_done_early", d_done, 0);
    tick();
    check("load_done_time", d_done, 1);
    d_req = 1'b0;
    tick();

    // half store
    push_wr(32'h3000, 8'hDD);
    push_wr(32'h3001, 8'hCC);
    push_resp(0, 0, '0);
    wr_base = wr_cnt;
    d_addr  = 32'h3000;
    d_size  = 2'b01;
    d_wr    = 1'b1;
    d_wdata = 32'hAABBCCDD;
    d_req   = 1'b1;
    wait_done("store_half", 4);
    check("store_mem_wr_in_done", mem_wr, 0);
    check("store_wr_cycles", wr_cnt - wr_base, 2);
    tick();

    // both requesting from reset: icache first, then data
    rst = 1'b1;
    ic_addr = 32'h1010;
    ic_req  = 1'b1;
    d_addr  = 32'h4007;
    d_size  = 2'b00;
    d_wr    = 1'b0;
    d_req   = 1'b1;
    push_resp(1, 1, exp_line(32'h1010));
    push_resp(0, 1, exp_load(32'h4007, 1));
    tick();
    tick();
    rst = 1'b0;
    wait_done("tie1_ic", LB + 2);
    wait_done("tie1_d", 1 + 3);
    tick();

    // icache alone, so last grant = icache
    ic_addr = 32'h1020;
    ic_req  = 1'b1;
    push_resp(1, 1, exp_line(32'h1020));
    wait_done("ic_alone", LB + 2);
    tick();

    // tie again: data wins this time
    ic_addr = 32'h1030;
    ic_req  = 1'b1;
    d_addr  = 32'h5001;
    d_size  = 2'b01;
    d_wr    = 1'b0;
    d_req   = 1'b1;
    push_resp(0, 1, exp_load(32'h5001, 2));
    push_resp(1, 1, exp_line(32'h1030));
    wait_done("tie2_d", 2 + 2);
    wait_done("tie2_ic", LB + 3);
    tick();

    // abort refill after 5 bytes with a data load pending
    ic_addr = 32'h1050;
    ic_req  = 1'b1;
    tick();
    d_addr = 32'h6003;
    d_size = 2'b00;
    d_wr   = 1'b0;
    d_req  = 1'b1;
    push_resp(0, 1, exp_load(32'h6003, 1));
    repeat (4) tick();
    check("abort_last_addr", mem_a, 32'h1054);
    ic_abort = 1'b1;
    tick();
    ic_abort = 1'b0;
    ic_req   = 1'b0;
    check("abort_addr_hold", mem_a, 32'h1054);
    check("abort_no_done", ic_done, 0);
    tick();
    check("abort_d_grant", mem_a, 32'h6003);
    wait_done("abort_d", 2);
    tick();

    // byte store into the IO window with the sink full
    push_wr(32'h30000, 8'h5A);
    push_resp(0, 0, '0);
    io_buffer_full = 1'b1;
    d_addr  = 32'h30000;
    d_size  = 2'b00;
    d_wr    = 1'b1;
    d_wdata = 32'h0000005A;
    d_req   = 1'b1;
`ifdef MEMCTL_IOSTALL_EN
    for (int i = 0; i < 3; i++) begin
      tick();
      check("iostall_hold", mem_wr, 0);
    end
    io_buffer_full = 1'b0;
    tick();
    check("iostall_release", mem_wr, 1);
    wait_done("iostall_d", 2);
`else
    tick();
    check("nostall_issue", mem_wr, 1);
    io_buffer_full = 1'b0;
    wait_done("nostall_d", 2);
`endif
    tick();

    // reset in the middle of a refill
    ic_addr = 32'h1060;
    ic_req  = 1'b1;
    repeat (7) tick();
    rst = 1'b1;
    tick();
    check("midrst_ic_done", ic_done, 0);
    check("midrst_d_done", d_done, 0);
    check("midrst_mem_wr", mem_wr, 0);
    check("midrst_mem_a", mem_a, 0);
    check("midrst_mem_dout", mem_dout, 0);
    check("midrst_ic_line", ic_line, 0);
    check("midrst_d_rdata", d_rdata, 0);
    ic_req = 1'b0;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check("midrst_no_done", ic_done, 0);

    check("sb_empty", sb.size(), 0);
    check("wq_empty", wq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Byte-serial main-memory controller shared by the instruction-cache refill path and the load/store data path. Grants one requester at a time via a two-way round-robin arbiter, then sequences the byte-wide RAM port: LINE_BYTES consecutive reads for a cache-line refill, or 1/2/4 reads or writes for a data access. Sits between the icache/LSB and the top-level RAM/IO bus.

## Interface
- LINE_BYTES, 16, bytes per icache line; power of two, ≥4; ic_line is 8*LINE_BYTES bits
- ADDR_W, 32, address width
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ic_req  in  1  line refill request; held until ic_done
- ic_addr  in  ADDR_W  refill address; low log2(LINE_BYTES) bits forced to 0
- ic_abort  in  1  cancel in-flight refill (branch flush)
- ic_done  out  1  one-cycle pulse, ic_line valid
- ic_line  out  8*LINE_BYTES  refilled line, byte i at [8i+7:8i]
- d_req  in  1  data request; held until d_done
- d_wr  in  1  1 store, 0 load
- d_size  in  2  00 byte, 01 half, 10/11 word
- d_addr  in  ADDR_W  data address (no alignment requirement)
- d_wdata  in  32  store data, little-endian
- d_done  out  1  one-cycle pulse; d_rdata valid for loads
- d_rdata  out  32  load data, zero-extended
- mem_din  in  8  RAM read byte
- mem_dout  out  8  RAM write byte
- mem_a  out  ADDR_W  RAM address
- mem_wr  out  1  RAM write strobe
- io_buffer_full  in  1  IO sink back-pressure

## Operation
- FSM: IDLE, BUSY, DONE. All outputs registered.
- IDLE: sample requests at each edge. One pending → grant it. Both pending → grant the one not granted last (last_grant reset value = data, so ifetch wins first tie). Latch op, address, N (LINE_BYTES, or 1/2/4), wdata; counter=0; → BUSY.
- BUSY read: issue mem_a=base+i, mem_wr=0 for i=0..N-1; byte i captured from mem_din at the edge two edges after its issue edge; after last capture → DONE.
- BUSY write: issue mem_a=base+i, mem_dout=wdata[8i+7:8i], mem_wr=1 for i=0..N-1; after last byte → DONE.
- DONE: pulse ic_done or d_done for one cycle; mem_wr=0; requests ignored; → IDLE. Requester drops req by the edge ending DONE.
- ic_abort high at any edge while a refill is BUSY or granted → stop issuing, no ic_done, → IDLE next cycle; ic_line contents undefined. ic_abort ignored for data ops and in IDLE (ic_req still sampled).
- Address increment wraps modulo 2^ADDR_W.
- Reset (any cycle, including mid-access): state IDLE, ic_done=d_done=mem_wr=0, mem_a=0, mem_dout=0, ic_line=0, d_rdata=0, last_grant=data; partial data discarded.

## Timing
- Grant sampled at edge T0. Byte i address on mem_a during cycle after edge T0+i.
- Read of N bytes: done high in cycle after edge T0+N+1 (N+2 cycles grant-to-done visible, counting the IDLE cycle).
- Write of N bytes: done high in cycle after edge T0+N+1; mem_wr low in done cycle.
- Next grant earliest at edge ending the cycle after DONE; minimum request spacing N+3 cycles.
- Idle bus: mem_wr=0, mem_a holds last value.

## Configuration
- MEMCTL_IOSTALL_EN defined: during a store, if mem_a's next address has addr[17:16]==2'b11 and io_buffer_full is high at the issue edge, that byte is not issued (mem_wr=0, counter held) and retried each edge until io_buffer_full is low. Loads and refills never stall.
- Undefined: io_buffer_full ignored; port kept for pin compatibility.

## Structure
- Shared utils.v: ADDR_TP, WORD_TP, TRUE/FALSE, d_size encodings, FSM state constants.
- One sub-module: mem_rr_arb (2-way round-robin, combinational grant plus registered last_grant).

## Test plan
- ic_req, ic_addr=0x1004, mem model returns byte=addr[7:0] → mem_a 0x1000..0x100F, ic_done once, ic_line=0x0F0E…0100.
- d_req load, d_size=10, d_addr=0x2002 → 4 reads 0x2002..0x2005, d_rdata=0x05040302, d_done once.
- d_req store, d_size=01, d_addr=0x3000, d_wdata=0xAABBCCDD → two writes: 0x3000←DD, 0x3001←CC, mem_wr exactly 2 cycles.
- ic_req and d_req both high from reset → refill granted first, then data; second simultaneous request after that → alternates.
- ic_abort after 5 refill bytes → no ic_done, IDLE next cycle, pending d_req granted at following edge.
- With MEMCTL_IOSTALL_EN, byte store to 0x30000, io_buffer_full high 3 cycles → mem_wr deferred 3 cycles, then one write; rst asserted mid-refill → all outputs 0 next cycle, no done.
